// File: rtl/pipe_stage_skid_reg.sv
//-----------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// Purpose:
//   Two-entry in-order pipeline register between an execute-type stage and a
//   memory-type stage. A main entry drives the out_* bus. A skid entry absorbs
//   one extra instruction, so in_ready can be decoded from registered state
//   alone, with no combinational path from out_ready.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  upstream handshake
//   in_ctrl         packed control (bit0 WB_en, bit1 MEM_R_EN, bit2 MEM_W_EN)
//   in_alu, in_st   ALU result and store value
//   in_dest         destination register index
//   flush           discard everything held (wins over freeze)
//   freeze          hold all state and hide both handshakes
//   out_valid/ready downstream handshake
//   out_ctrl/alu/st/dest  oldest held instruction (ctrl zeroed on bubbles)
//   occupancy       number of held entries, 0..2
//-----------------------------------------------------------------------------

// Invariant checker; kept apart from the datapath and bound in from the top.
module pipe_stage_skid_reg_chk #(
  parameter int CTRL_W = 3
) (
  input logic              clk,
  input logic              rst,
  input logic              freeze,
  input logic              in_ready,
  input logic              out_valid,
  input logic [CTRL_W-1:0] out_ctrl,
  input logic [1:0]        occupancy
);

  a_occ_range: assert property (@(posedge clk) disable iff (rst)
    occupancy != 2'd3);

  a_bubble_ctrl: assert property (@(posedge clk) disable iff (rst)
    !out_valid |-> (out_ctrl == {CTRL_W{1'b0}}));

  a_full_not_ready: assert property (@(posedge clk) disable iff (rst)
    (occupancy == 2'd2) |-> !in_ready);

  a_freeze_hides: assert property (@(posedge clk) disable iff (rst)
    freeze |-> (!in_ready && !out_valid));

  a_empty_not_valid: assert property (@(posedge clk) disable iff (rst)
    (occupancy == 2'd0) |-> !out_valid);

endmodule

module pipe_stage_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_st,
  input  logic [DEST_W-1:0] in_dest,

  input  logic              flush,
  input  logic              freeze,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_st,
  output logic [DEST_W-1:0] out_dest,

  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_alu_q,  main_alu_d;
  logic [DATA_W-1:0] main_st_q,   main_st_d;
  logic [DEST_W-1:0] main_dest_q, main_dest_d;

  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_alu_q,  skid_alu_d;
  logic [DATA_W-1:0] skid_st_q,   skid_st_d;
  logic [DEST_W-1:0] skid_dest_q, skid_dest_d;

  logic tin;
  logic tout;

  // Handshakes depend only on registered state plus freeze/rst, never on
  // out_ready, so this stage breaks the ready path.
  assign in_ready  = !rst && !freeze && (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY) && !freeze;

  assign tin  = in_valid && in_ready;
  assign tout = out_valid && out_ready;

  // Output bus: data fields always show the main entry (so they hold while
  // idle); ctrl is masked so a bubble can never write.
  always_comb begin
    out_alu  = main_alu_q;
    out_st   = main_st_q;
    out_dest = main_dest_q;
    if (out_valid) begin
      out_ctrl = main_ctrl_q;
    end else begin
      out_ctrl = {CTRL_W{1'b0}};
    end
  end

  // Occupancy decode from state.
  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_EMPTY: occupancy = 2'd0;
      ST_ONE:   occupancy = 2'd1;
      ST_TWO:   occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  end

  // Next-state and entry update.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_alu_d  = main_alu_q;
    main_st_d   = main_st_q;
    main_dest_d = main_dest_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_alu_d  = skid_alu_q;
    skid_st_d   = skid_st_q;
    skid_dest_d = skid_dest_q;

    if (flush) begin
      // Flush beats freeze and any transfer. Data fields are left alone so
      // out_alu/out_st/out_dest keep their last value; only ctrl is cleared.
      state_d     = ST_EMPTY;
      main_ctrl_d = {CTRL_W{1'b0}};
      skid_ctrl_d = {CTRL_W{1'b0}};
    end else begin
      // Under freeze tin and tout are both 0, so every branch below holds.
      case (state_q)
        ST_EMPTY: begin
          if (tin) begin
            main_ctrl_d = in_ctrl;
            main_alu_d  = in_alu;
            main_st_d   = in_st;
            main_dest_d = in_dest;
            state_d     = ST_ONE;
          end else begin
            state_d     = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (tin && !tout) begin
            skid_ctrl_d = in_ctrl;
            skid_alu_d  = in_alu;
            skid_st_d   = in_st;
            skid_dest_d = in_dest;
            state_d     = ST_TWO;
          end else if (tout && !tin) begin
            state_d     = ST_EMPTY;
          end else if (tin && tout) begin
            // Pass-through: the new instruction replaces the departing one.
            main_ctrl_d = in_ctrl;
            main_alu_d  = in_alu;
            main_st_d   = in_st;
            main_dest_d = in_dest;
            state_d     = ST_ONE;
          end else begin
            state_d     = ST_ONE;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a departure can happen.
          if (tout) begin
            main_ctrl_d = skid_ctrl_q;
            main_alu_d  = skid_alu_q;
            main_st_d   = skid_st_q;
            main_dest_d = skid_dest_q;
            state_d     = ST_ONE;
          end else begin
            state_d     = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and entry registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= {CTRL_W{1'b0}};
      main_alu_q  <= {DATA_W{1'b0}};
      main_st_q   <= {DATA_W{1'b0}};
      main_dest_q <= {DEST_W{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
      skid_alu_q  <= {DATA_W{1'b0}};
      skid_st_q   <= {DATA_W{1'b0}};
      skid_dest_q <= {DEST_W{1'b0}};
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_alu_q  <= main_alu_d;
      main_st_q   <= main_st_d;
      main_dest_q <= main_dest_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_alu_q  <= skid_alu_d;
      skid_st_q   <= skid_st_d;
      skid_dest_q <= skid_dest_d;
    end
  end

  pipe_stage_skid_reg_chk #(
    .CTRL_W (CTRL_W)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
`timescale 1ns/1ps
// Testbench for pipe_stage_skid_reg: directed scenarios with literal
// expectations, then randomized valid/ready/freeze/flush traffic, all checked
// every cycle against a queue-based model of the stage.
module tb_pipe_stage_skid_reg;

  localparam int DW = 64;
  localparam int RW = 6;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_alu;
  logic [DW-1:0] in_st;
  logic [RW-1:0] in_dest;
  logic          flush;
  logic          freeze;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_alu;
  logic [DW-1:0] out_st;
  logic [RW-1:0] out_dest;
  logic [1:0]    occupancy;

  pipe_stage_skid_reg #(.DATA_W(DW), .DEST_W(RW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_alu    (in_alu),
    .in_st     (in_st),
    .in_dest   (in_dest),
    .flush     (flush),
    .freeze    (freeze),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_alu   (out_alu),
    .out_st    (out_st),
    .out_dest  (out_dest),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model: a FIFO of at most two ----------------
  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] alu;
    logic [DW-1:0] st;
    logic [RW-1:0] dest;
  } ent_t;

  ent_t mq[$];
  ent_t hold = '0;   // what the output data bus shows (front, or last front)
  ent_t tmp;
  bit   m_rdy, m_vld;
  bit   e_rdy, e_vld;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      hold = '0;
    end else begin
      m_rdy = !freeze && (mq.size() < 2);
      m_vld = !freeze && (mq.size() > 0);
      if (flush) begin
        mq.delete();
      end else begin
        if (m_vld && out_ready) void'(mq.pop_front());
        if (in_valid && m_rdy) begin
          tmp.ctrl = in_ctrl; tmp.alu = in_alu; tmp.st = in_st; tmp.dest = in_dest;
          mq.push_back(tmp);
        end
      end
      if (mq.size() > 0) hold = mq[0];
    end
  end

  // Compare process: every cycle, mid low phase, after inputs have settled.
  initial forever begin
    @(negedge clk);
    #2;
    e_vld = !freeze && (mq.size() > 0);
    e_rdy = !rst && !freeze && (mq.size() < 2);
    chk("in_ready",  64'(in_ready),  64'(e_rdy));
    chk("out_valid", 64'(out_valid), 64'(e_vld));
    chk("out_ctrl",  64'(out_ctrl),  e_vld ? 64'(hold.ctrl) : 64'd0);
    chk("out_alu",   out_alu,        hold.alu);
    chk("out_st",    out_st,         hold.st);
    chk("out_dest",  64'(out_dest),  64'(hold.dest));
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] a,
                       input bit ordy, input bit frz, input bit fl, input bit r);
    @(negedge clk);
    rst = r; in_valid = v; in_ctrl = c; in_alu = a; in_st = ~a; in_dest = a[RW-1:0];
    out_ready = ordy; freeze = frz; flush = fl;
    #3;
  endtask

  task automatic drv(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] a, input bit ordy);
    drive(v, c, a, ordy, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_alu = '0; in_st = '0; in_dest = '0;
    out_ready = 1'b0; freeze = 1'b0; flush = 1'b0;

    // Reset state
    drive(1'b0, 3'b000, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_occ",       64'(occupancy), 64'd0);
    chk("rst_out_alu",   out_alu,        64'd0);

    // Streaming A,B,C with out_ready held high; first tin right after reset
    drv(1'b1, 3'b001, 64'hA1, 1'b1);
    chk("s_in_ready0", 64'(in_ready), 64'd1);
    drv(1'b1, 3'b001, 64'hB1, 1'b1);
    chk("s_out_A", out_alu, 64'hA1);
    chk("s_occ1",  64'(occupancy), 64'd1);
    drv(1'b1, 3'b001, 64'hC1, 1'b1);
    chk("s_out_B", out_alu, 64'hB1);
    chk("s_in_ready", 64'(in_ready), 64'd1);
    drv(1'b0, 3'b000, 64'd0, 1'b1);
    chk("s_out_C", out_alu, 64'hC1);
    chk("s_ctrl",  64'(out_ctrl), 64'd1);
    drv(1'b0, 3'b000, 64'd0, 1'b1);
    chk("s_idle_valid", 64'(out_valid), 64'd0);
    chk("s_idle_ctrl",  64'(out_ctrl),  64'd0);
    chk("s_idle_hold",  out_alu,        64'hC1);

    // Backpressure fills to TWO, then drains in order
    drv(1'b1, 3'b011, 64'hA2, 1'b0);
    drv(1'b1, 3'b011, 64'hB2, 1'b0);
    chk("bp_ready_in_one", 64'(in_ready), 64'd1);
    drv(1'b0, 3'b000, 64'd0, 1'b0);
    chk("bp_occ2",   64'(occupancy), 64'd2);
    chk("bp_ready0", 64'(in_ready),  64'd0);
    drv(1'b0, 3'b000, 64'd0, 1'b1);
    chk("bp_out_A", out_alu, 64'hA2);
    drv(1'b0, 3'b000, 64'd0, 1'b1);
    chk("bp_out_B",  out_alu, 64'hB2);
    chk("bp_ready1", 64'(in_ready), 64'd1);
    drv(1'b0, 3'b000, 64'd0, 1'b1);

    // Freeze in TWO for three cycles
    drv(1'b1, 3'b010, 64'hA3, 1'b0);
    drv(1'b1, 3'b010, 64'hB3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'b000, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("fz_valid", 64'(out_valid), 64'd0);
      chk("fz_ready", 64'(in_ready),  64'd0);
      chk("fz_occ",   64'(occupancy), 64'd2);
    end
    drv(1'b0, 3'b000, 64'd0, 1'b1);
    chk("fz_out_A", out_alu, 64'hA3);
    drv(1'b0, 3'b000, 64'd0, 1'b1);
    chk("fz_out_B", out_alu, 64'hB3);
    drv(1'b0, 3'b000, 64'd0, 1'b1);

    // Flush with freeze and an incoming instruction in TWO
    drv(1'b1, 3'b100, 64'hA4, 1'b0);
    drv(1'b1, 3'b100, 64'hB4, 1'b0);
    drive(1'b1, 3'b111, 64'hEE, 1'b1, 1'b1, 1'b1, 1'b0);
    drv(1'b0, 3'b000, 64'd0, 1'b1);
    chk("fl_occ0",  64'(occupancy), 64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ctrl",  64'(out_ctrl),  64'd0);
    drv(1'b0, 3'b000, 64'd0, 1'b1);
    chk("fl_never", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges while holding ctrl=101
    drv(1'b1, 3'b101, 64'hA5, 1'b0);
    drv(1'b0, 3'b000, 64'd0, 1'b0);
    chk("ar_ctrl_pre", 64'(out_ctrl), 64'd5);
    chk("ar_alu_pre",  out_alu,       64'hA5);
    #1 rst = 1'b1;
    #1;
    chk("ar_ctrl", 64'(out_ctrl),  64'd0);
    chk("ar_alu",  out_alu,        64'd0);
    chk("ar_occ",  64'(occupancy), 64'd0);
    drive(1'b0, 3'b000, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random stress
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, CW'($urandom), {$urandom, $urandom},
            ($urandom % 3) != 0, ($urandom % 8) == 0, ($urandom % 40) == 0, 1'b0);
    end
    for (int i = 0; i < 4; i++) drv(1'b0, 3'b000, 64'd0, 1'b1);
    chk("end_empty", 64'(occupancy), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
